// File: rtl/l1_avgpool_stage.sv
// l1_avgpool_stage
//   2x2 stride-2 average pool over the 32x32 layer-1 map (bank SEL_RD).
//   The 16x16 result goes to bank SEL_WR with round-half-up. The block also
//   tracks the largest value it writes.
//
// State table
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for start; outputs quiet, csel holds last value
//   S_READ  | 4 cycles, crd=1, presents tap k address (k=0..3)
//   S_LAST  | crd=0, captures tap 3, registers result for the write
//   S_WRITE | cwr=1 for output o; then next window or finish
//   S_FIN   | done pulse, busy still high
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   start     one-cycle start pulse, honoured only in S_IDLE
//   busy      high from the cycle after start until S_FIN completes
//   done      one-cycle pulse in S_FIN
//   crd       read strobe, caddr_rd read address, cdata_rd read data
//   cwr       write strobe, caddr_wr write address, cdata_wr write data
//   csel      memory bank select
//   gmax      maximum written value, valid at done
module l1_avgpool_stage #(
  parameter logic [2:0] SEL_RD  = 3'b011,
  parameter logic [2:0] SEL_WR  = 3'b101,
  parameter int         IN_DIM  = 32,
  parameter int         OUT_DIM = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic [2:0]  csel,
  output logic [19:0] gmax
);

  localparam logic [7:0] O_LAST = 8'(OUT_DIM * OUT_DIM - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LAST, S_WRITE, S_FIN} state_t;

  state_t      state, state_nxt;
  logic [7:0]  o;
  logic [1:0]  k;
  logic [21:0] acc;
  logic [21:0] tap;
  logic [21:0] sum_rnd;
  logic [19:0] res;

  // Window base is (2*oy)*IN_DIM + 2*ox. Tap order is TL, TR, BL, BR.
  function automatic logic [11:0] rd_addr(input logic [7:0] idx, input logic [1:0] kk);
    logic [9:0] base;
    base = {idx[7:4], 1'b0, idx[3:0], 1'b0};
    return {2'b00, base + (kk[1] ? 10'(IN_DIM) : 10'd0) + {9'd0, kk[0]}};
  endfunction

  // Negative taps (bit 19 set) contribute zero.
  assign tap     = cdata_rd[19] ? 22'd0 : {2'b00, cdata_rd};
  assign sum_rnd = acc + tap + 22'd2;
  assign res     = sum_rnd[21:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  if (k == 2'd3) state_nxt = S_LAST;
      S_LAST:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = (o == O_LAST) ? S_FIN : S_READ;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered on the edge that enters the state they belong to.
  // Taps 0..2 are captured at the end of READ k=0..2. Tap 3 is captured at the
  // end of LAST, while its address is still on caddr_rd.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o        <= '0;
      k        <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      csel     <= 3'b000;
      gmax     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            o        <= '0;
            k        <= '0;
            acc      <= '0;
            gmax     <= '0;
            busy     <= 1'b1;
            crd      <= 1'b1;
            csel     <= SEL_RD;
            caddr_rd <= rd_addr(8'd0, 2'd0);
          end
        end
        S_READ: begin
          if (k == 2'd3) begin
            crd <= 1'b0;
          end else begin
            acc      <= acc + tap;
            k        <= k + 2'd1;
            caddr_rd <= rd_addr(o, k + 2'd1);
          end
        end
        S_LAST: begin
          cdata_wr <= res;
          if (res > gmax) gmax <= res;
          acc      <= '0;
          cwr      <= 1'b1;
          csel     <= SEL_WR;
          caddr_wr <= {4'b0000, o};
        end
        S_WRITE: begin
          cwr <= 1'b0;
          k   <= '0;
          if (o == O_LAST) begin
            done <= 1'b1;
          end else begin
            o        <= o + 8'd1;
            crd      <= 1'b1;
            csel     <= SEL_RD;
            caddr_rd <= rd_addr(o + 8'd1, 2'd0);
          end
        end
        S_FIN: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_avgpool_stage.sv
module tb_l1_avgpool_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, crd, cwr;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_rd, cdata_wr, gmax;
  logic [2:0]  csel;

  logic [19:0] mem  [0:1023];
  logic [19:0] wmem [0:255];

  typedef struct {
    logic [11:0] addr;
    logic [19:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_wq[$];
  logic [11:0] exp_rq[$];
  logic [19:0] exp_gmax;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc_total = 0;
  int          run_base  = 0;
  bit          done_seen;

  l1_avgpool_stage dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel),
    .gmax     (gmax)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_total <= cyc_total + 1;

  assign cdata_rd = mem[caddr_rd[9:0]];
  always @(posedge clk) if (cwr) wmem[caddr_wr[7:0]] <= cdata_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each output is the rounded mean of its 2x2 window, negatives as 0.
  task automatic build_expect();
    logic [19:0] v;
    int sum, r;
    wr_t w;
    exp_wq.delete();
    exp_rq.delete();
    exp_gmax = '0;
    for (int oy = 0; oy < 16; oy++) begin
      for (int ox = 0; ox < 16; ox++) begin
        sum = 0;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            int a;
            a = (2 * oy + dy) * 32 + 2 * ox + dx;
            exp_rq.push_back(12'(a));
            v = mem[a];
            if (v >= 20'h80000) v = 20'h0;
            sum += int'(v);
          end
        end
        r = (sum + 2) / 4;
        w.addr = 12'(oy * 16 + ox);
        w.data = 20'(r);
        w.cyc  = 6 + 6 * (oy * 16 + ox);
        exp_wq.push_back(w);
        if (20'(r) > exp_gmax) exp_gmax = 20'(r);
      end
    end
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (crd || cwr) check("crd_cwr_exclusive", 32'(crd & cwr), 32'd0);
      if (crd) begin
        check("csel_on_read", 32'(csel), 32'(3'b011));
        if (exp_rq.size() == 0) check("unexpected_read", 32'(caddr_rd), 32'hFFFFFFFF);
        else check("read_addr", 32'(caddr_rd), 32'(exp_rq.pop_front()));
      end
      if (cwr) begin
        check("csel_on_write", 32'(csel), 32'(3'b101));
        if (exp_wq.size() == 0) check("unexpected_write", 32'(caddr_wr), 32'hFFFFFFFF);
        else begin
          wr_t w;
          w = exp_wq.pop_front();
          check("write_addr", 32'(caddr_wr), 32'(w.addr));
          check("write_data", 32'(cdata_wr), 32'(w.data));
          check("write_cycle", 32'(cyc_total - run_base), 32'(w.cyc));
        end
      end
      if (done) begin
        done_seen = 1'b1;
        check("done_cycle", 32'(cyc_total - run_base), 32'd1537);
        check("done_busy", 32'(busy), 32'd1);
        check("gmax_at_done", 32'(gmax), 32'(exp_gmax));
        check("writes_left_at_done", 32'(exp_wq.size()), 32'd0);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start    = 1'b1;
    run_base = cyc_total;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_run(input int stray_at);
    build_expect();
    done_seen = 1'b0;
    pulse_start();
    for (int i = 0; i < 1600 && !done_seen; i++) begin
      @(negedge clk);
      start = (i == stray_at);
    end
    start = 1'b0;
    check("run_completed", 32'(done_seen), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("idle_busy_after_run", 32'(busy), 32'd0);
    check("idle_done_after_run", 32'(done), 32'd0);
  endtask

  task automatic fill_random();
    logic [19:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = 20'($urandom_range(0, 20'h7FFFF));
      if ($urandom_range(0, 3) == 0) v = v | 20'h80000;
      mem[i] = v;
    end
  endtask

  task automatic set_window(input int o, input logic [19:0] a, input logic [19:0] b,
                            input logic [19:0] c, input logic [19:0] d);
    int base;
    base = (o / 16) * 64 + (o % 16) * 2;
    mem[base] = a; mem[base + 1] = b; mem[base + 32] = c; mem[base + 33] = d;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_crd"}, 32'(crd), 32'd0);
    check({tag, "_cwr"}, 32'(cwr), 32'd0);
    check({tag, "_caddr_rd"}, 32'(caddr_rd), 32'd0);
    check({tag, "_caddr_wr"}, 32'(caddr_wr), 32'd0);
    check({tag, "_cdata_wr"}, 32'(cdata_wr), 32'd0);
    check({tag, "_csel"}, 32'(csel), 32'd0);
    check({tag, "_gmax"}, 32'(gmax), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Reset held: start toggles must have no effect
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = ~start;
    end
    start = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_outputs_zero("idle_after_release");

    // Constant map
    for (int i = 0; i < 1024; i++) mem[i] = 20'h00010;
    do_run(-1);
    check("const_gmax", 32'(gmax), 32'h10);
    check("const_word0", 32'(wmem[0]), 32'h10);
    check("const_word255", 32'(wmem[255]), 32'h10);

    // Rounding, saturation-free maximum and negative clamp
    fill_random();
    set_window(0, 20'd1, 20'd1, 20'd1, 20'd0);
    set_window(1, 20'd1, 20'd1, 20'd0, 20'd0);
    set_window(2, 20'd1, 20'd0, 20'd0, 20'd0);
    set_window(3, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF);
    set_window(4, 20'h80000, 20'd4, 20'd4, 20'd4);
    do_run(-1);
    check("round_111_0", 32'(wmem[0]), 32'd1);
    check("round_11_00", 32'(wmem[1]), 32'd1);
    check("round_1_000", 32'(wmem[2]), 32'd0);
    check("max_window", 32'(wmem[3]), 32'h7FFFF);
    check("neg_clamp", 32'(wmem[4]), 32'd3);
    check("max_gmax", 32'(gmax), 32'h7FFFF);

    // Address walk with a stray start pulse mid-run
    for (int i = 0; i < 1024; i++) mem[i] = 20'(i);
    do_run(300);
    check("walk_last", 32'(wmem[255]), 32'd1007);

    // Fully random map
    fill_random();
    do_run(-1);

    // Abort during the write of o=40, then restart from o=0
    fill_random();
    build_expect();
    done_seen = 1'b0;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (cwr && caddr_wr == 12'd40) found = 1'b1;
    end
    check("abort_point_reached", 32'(found), 32'd1);
    #2;
    reset = 1'b0;
    exp_wq.delete();
    exp_rq.delete();
    #1;
    check_outputs_zero("abort");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_cwr", 32'(cwr), 32'd0);
    check("abort_no_done", 32'(done_seen), 32'd0);
    do_run(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_avgpool_stage.md
Name: l1_avgpool_stage

Overview:
- Downstream consumer of the convolution/max-pool engine's layer-1 output: a 32x32 map of 20-bit non-negative fixed-point values, stored in the shared testbench memory bank selected by csel=3'b011.
- Computes a 2x2 stride-2 average pool with round-half-up. Writes the resulting 16x16 map (256 words) to bank csel=3'b101.
- Tracks the global maximum of the written results.
- Started by a one-cycle pulse that the top level issues when the upstream engine drops busy.

Parameters:
- SEL_RD, 3'b011, csel value during reads (layer-1 bank).
- SEL_WR, 3'b101, csel value during writes (layer-2 bank).
- IN_DIM, 32, input map width/height. Fixed; addressing below assumes 32.
- OUT_DIM, 16, output map width/height (IN_DIM/2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle start pulse; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until FIN completes.
- done  out  1  one-cycle pulse in FIN.
- crd  out  1  memory read strobe.
- caddr_rd  out  12  read address; upper 2 bits always 0.
- cdata_rd  in  20  read data; memory drives it combinationally from caddr_rd.
- cwr  out  1  memory write strobe.
- caddr_wr  out  12  write address; upper 4 bits always 0.
- cdata_wr  out  20  write data.
- csel  out  3  memory bank select.
- gmax  out  20  maximum written value; valid when done=1; held until next start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. busy, done, crd and cwr are 0. caddr_rd, caddr_wr, cdata_wr and gmax are 0. csel=3'b000. Internal counters and accumulator are cleared.
- Reset mid-operation aborts immediately. No further writes are issued. After reset releases, the block waits for a new start.
- All outputs are registered. In a given cycle, their values reflect the current state.

State machine (IDLE, READ, LAST, WRITE, FIN):
- IDLE: busy=0, crd=0, cwr=0. When start=1, clear the output index o (8 bits, o={oy,ox}), the accumulator and gmax. Then go to READ.
- start while busy=1 is ignored.
- READ (4 cycles, k=0..3):
  - crd=1, csel=SEL_RD, caddr_rd = base + {0,1,32,33}[k], where base = {oy,1'b0,ox,1'b0}.
  - In cycles k=1..3, the block samples cdata_rd for tap k-1 at the clock edge.
- LAST (1 cycle): crd=0. The block samples cdata_rd for tap 3. caddr_rd holds its last value.
- WRITE (1 cycle):
  - cwr=1, csel=SEL_WR, caddr_wr={4'b0,o}.
  - cdata_wr = (sum+2)>>2, where sum is the 22-bit unsigned sum of the 4 taps.
  - gmax = max(gmax, result).
  - If o=255, go to FIN. Otherwise increment o and go to READ.
- FIN (1 cycle): done=1, busy=1, cwr=0. Then IDLE, where busy=0.

Arithmetic:
- Any tap with bit 19 set (negative) is treated as 0 before accumulation.
- The result never exceeds 20'h7FFFF, so no saturation stage is needed.
- Round-half-up: remainder 2 or 3 rounds up.

Timing:
- One output every 6 cycles.
- The start-accept edge is E0. The first WRITE is cycle 6 after E0. The last WRITE is cycle 1536. done is high in cycle 1537.

Mutual exclusion and gaps:
- crd and cwr are never high in the same cycle.
- csel changes only at READ entry and at WRITE entry.
- During LAST and FIN, csel holds its prior value. In IDLE, it holds 3'b000 after reset, otherwise its last value.

Address walk:
- ox increments fastest. At ox=15 it wraps to 0 and oy increments.
- At o=255 there is no wrap; the block goes to FIN.
- Read addresses never exceed 1023.

Test Plan:
- Reset and idle: hold reset=0 and toggle start -> all outputs 0, busy stays 0. Release reset with start=0 -> still idle, no crd/cwr activity.
- Constant map: every L1 word = 20'h00010, pulse start -> 256 writes to addresses 0..255 with cdata_wr=20'h00010, gmax=20'h00010, done pulse in cycle 1537.
- Rounding: first window = {1,1,1,0} -> addr 0 gets 1 (sum 3, +2, >>2). Window {1,1,0,0} -> 1. Window {1,0,0,0} -> 0. Window {7FFFF x4} -> 7FFFF, and gmax=7FFFF.
- Address walk: L1 word i = i, sample the read sequence -> o=0 reads 0,1,32,33; o=15 reads 30,31,62,63; o=16 reads 64,65,96,97; o=255 reads 990,991,1022,1023.
- Negative clamp: window {20'h80000, 4, 4, 4} -> write value 3. crd/cwr are never both 1, and csel=3'b011 whenever crd=1 and 3'b101 whenever cwr=1.
- Abort and restart: assert reset=0 during WRITE of o=40 -> no cwr after reset. Pulse start again after release -> full run from o=0. A start pulse mid-run has no effect on the address sequence.
